// File: rtl/msg_scheduler.sv
// SHA-256 message schedule: fetches W0..W15 for one block, expands to W0..W63 in a
// 16-word circular window and streams W_t over valid/ready. Option: MSG_SCHED_PASSTHRU_EN.
module msg_scheduler #(
    parameter int ADDR_W = 8,
    parameter int BLK_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BLK_W-1:0]  block_idx,
    output logic              req_word,
    output logic [ADDR_W-1:0] word_address,
    input  logic [31:0]       word_data,
    input  logic              word_valid,
    output logic [31:0]       w_data,
    output logic [5:0]        w_index,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              busy,
    output logic              block_done
);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

    state_t            state, state_next;
    logic [BLK_W-1:0]  blk;
    logic [3:0]        fetch_idx;
    logic [31:0]       window [16];
    logic              capture;
    logic              accept;
    logic [5:0]        next_t;
    logic [3:0]        next_lo;
    logic [31:0]       next_w;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign word_address = ADDR_W'({blk, fetch_idx});
    assign capture      = req_word && word_valid;
    assign accept       = w_valid && w_ready;

    // The word following W_t never depends on W_t, so it can be built from the window
    // in the same cycle that W_t is written back.
    always_comb begin
        next_t  = w_index + 6'd1;
        next_lo = next_t[3:0];
        if (next_t < 6'd16) begin
            next_w = window[next_lo];
        end else begin
            next_w = sig1(window[next_lo - 4'd2]) + window[next_lo - 4'd7]
                   + sig0(window[next_lo - 4'd15]) + window[next_lo];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_word   = 1'b0;
        busy       = (state != IDLE);
        block_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
`ifdef MSG_SCHED_PASSTHRU_EN
                req_word = !w_valid;
`else
                req_word = 1'b1;
`endif
                if (capture && fetch_idx == 4'd15) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (accept && w_index == 6'd63) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                block_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk       <= '0;
            fetch_idx <= '0;
            w_valid   <= 1'b0;
            w_data    <= '0;
            w_index   <= '0;
            for (int k = 0; k < 16; k++) begin
                window[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        blk       <= block_idx;
                        fetch_idx <= '0;
                    end
                end
                FETCH: begin
                    if (capture) begin
                        window[fetch_idx] <= word_data;
                        if (fetch_idx != 4'd15) begin
                            fetch_idx <= fetch_idx + 4'd1;
                        end
                    end
`ifdef MSG_SCHED_PASSTHRU_EN
                    // Each fetched word is offered immediately; the last one stays pending into EMIT.
                    if (capture) begin
                        w_valid <= 1'b1;
                        w_data  <= word_data;
                        w_index <= {2'b00, fetch_idx};
                    end else if (accept) begin
                        w_valid <= 1'b0;
                    end
`else
                    if (capture && fetch_idx == 4'd15) begin
                        w_valid <= 1'b1;
                        w_data  <= window[0];
                        w_index <= '0;
                    end
`endif
                end
                EMIT: begin
                    if (accept) begin
                        if (w_index >= 6'd16) begin
                            window[w_index[3:0]] <= w_data;
                        end
                        if (w_index == 6'd63) begin
                            w_valid <= 1'b0;
                        end else begin
                            w_index <= next_t;
                            w_data  <= next_w;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_scheduler.sv
// Self-checking bench for msg_scheduler: random and "abc" blocks against an array-based
// SHA-256 schedule model; handles either setting of MSG_SCHED_PASSTHRU_EN.
module tb_msg_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  block_idx;
    logic        req_word;
    logic [7:0]  word_address;
    logic [31:0] word_data;
    logic        word_valid;
    logic [31:0] w_data;
    logic [5:0]  w_index;
    logic        w_valid;
    logic        w_ready;
    logic        busy;
    logic        block_done;

    int checks = 0;
    int passed = 0;

    logic [31:0] blk_words [16];
    logic [31:0] exp_w [64];

    logic [31:0] got_data [64];
    int          got_idx [64];
    int          acc_cyc [64];
    logic [7:0]  addr_log [16];
    int          cap_cyc [16];
    int n_got, n_cap, first_valid_cyc, done_cyc, done_pulses;
    int hold_err, addr_err, extra_req;
    bit timeout, aborted;

    msg_scheduler #(.ADDR_W(8), .BLK_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .block_idx(block_idx),
        .req_word(req_word), .word_address(word_address), .word_data(word_data),
        .word_valid(word_valid), .w_data(w_data), .w_index(w_index), .w_valid(w_valid),
        .w_ready(w_ready), .busy(busy), .block_done(block_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Full 64-entry schedule from the textbook recurrence
    function automatic void build_expected();
        logic [31:0] a, b;
        for (int t = 0; t < 16; t++) exp_w[t] = blk_words[t];
        for (int t = 16; t < 64; t++) begin
            a = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
            b = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
            exp_w[t] = b + exp_w[t-7] + a + exp_w[t-16];
        end
    endfunction

    function automatic void fill_abc();
        for (int k = 0; k < 16; k++) blk_words[k] = 32'h0;
        blk_words[0]  = 32'h61626380;
        blk_words[15] = 32'h00000018;
        build_expected();
    endfunction

    function automatic void fill_random();
        for (int k = 0; k < 16; k++) blk_words[k] = $urandom;
        build_expected();
    endfunction

    // Drives one block through the DUT on negedges and records everything observed
    task automatic run_block(input logic [3:0] blk, input int wv_delay, input bit rand_ready,
                             input bit poke_start, input int abort_t);
        bit          pend_hold, waiting, finished;
        logic [31:0] hold_d;
        logic [5:0]  hold_i;
        logic [7:0]  wait_addr;
        int          wait_cnt;
        pend_hold = 0; waiting = 0; finished = 0; wait_cnt = 0;
        hold_d = '0; hold_i = '0; wait_addr = '0;
        n_got = 0; n_cap = 0; first_valid_cyc = -1; done_cyc = -1; done_pulses = 0;
        hold_err = 0; addr_err = 0; extra_req = 0; timeout = 0; aborted = 0;
        for (int k = 0; k < 64; k++) begin
            got_data[k] = 'x; got_idx[k] = -1; acc_cyc[k] = -1;
        end
        for (int k = 0; k < 16; k++) begin
            addr_log[k] = 'x; cap_cyc[k] = -1;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (pend_hold && (w_valid !== 1'b1 || w_data !== hold_d || w_index !== hold_i))
                hold_err++;
            if (cyc > 0 && n_got >= 64 && busy === 1'b0) begin
                finished = 1;
                break;
            end
            if (abort_t >= 0 && w_valid === 1'b1 && int'(w_index) == abort_t) begin
                rst_n = 1'b0;
                aborted = 1;
                break;
            end
            start = (cyc == 0) || (poke_start && (cyc == 5 || cyc == 30 || cyc == 60));
            block_idx = (cyc == 0) ? blk : ~blk;
            if (block_done === 1'b1) begin
                done_pulses++;
                done_cyc = cyc;
            end
            if (w_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (req_word === 1'b1 && n_cap >= 16) extra_req++;
            if (req_word === 1'b1) begin
                if (waiting && word_address !== wait_addr) addr_err++;
                waiting = 1;
                wait_addr = word_address;
                word_valid = (wait_cnt >= wv_delay);
            end else begin
                word_valid = 1'b0;
            end
            word_data = blk_words[word_address[3:0]];
            if (req_word === 1'b1 && word_valid) begin
                if (n_cap < 16) begin
                    addr_log[n_cap] = word_address;
                    cap_cyc[n_cap] = cyc;
                end
                n_cap++;
                waiting = 0;
                wait_cnt = 0;
            end else if (req_word === 1'b1) begin
                wait_cnt++;
            end
            w_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (w_valid === 1'b1 && w_ready) begin
                if (n_got < 64) begin
                    got_data[n_got] = w_data;
                    got_idx[n_got] = int'(w_index);
                    acc_cyc[n_got] = cyc;
                end
                n_got++;
            end
            pend_hold = (w_valid === 1'b1) && !w_ready;
            hold_d = w_data;
            hold_i = w_index;
        end
        start = 1'b0;
        word_valid = 1'b0;
        w_ready = 1'b0;
        if (!finished && !aborted) timeout = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; block_idx = '0; word_valid = 1'b0;
        word_data = '0; w_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_word !== 1'b0) $display("[TB] FAIL reset_req_word: got %b want 0", req_word); else passed++;
        checks++; if (w_valid !== 1'b0) $display("[TB] FAIL reset_w_valid: got %b want 0", w_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (block_done !== 1'b0) $display("[TB] FAIL reset_block_done: got %b want 0", block_done); else passed++;
        checks++; if (w_data !== 32'h0) $display("[TB] FAIL reset_w_data: got %h want 0", w_data); else passed++;
        checks++; if (w_index !== 6'h0) $display("[TB] FAIL reset_w_index: got %0d want 0", w_index); else passed++;
        checks++; if (word_address !== 8'h0) $display("[TB] FAIL reset_word_address: got %h want 0", word_address); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_abc_stream();
        fill_abc();
        run_block(4'd0, 0, 1'b0, 1'b0, -1);
        checks++; if (timeout) $display("[TB] FAIL abc_timeout: got %0d words want 64", n_got); else passed++;
        checks++; if (n_got !== 64) $display("[TB] FAIL abc_count: got %0d want 64", n_got); else passed++;
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (got_data[k] !== exp_w[k] || got_idx[k] !== k)
                $display("[TB] FAIL abc_W%0d: got %h idx %0d want %h idx %0d", k, got_data[k], got_idx[k], exp_w[k], k);
            else passed++;
        end
        checks++; if (got_data[0] !== 32'h61626380) $display("[TB] FAIL abc_vec_W0: got %h want 61626380", got_data[0]); else passed++;
        checks++; if (got_data[15] !== 32'h00000018) $display("[TB] FAIL abc_vec_W15: got %h want 00000018", got_data[15]); else passed++;
        checks++; if (got_data[16] !== 32'h61626380) $display("[TB] FAIL abc_vec_W16: got %h want 61626380", got_data[16]); else passed++;
        checks++; if (got_data[17] !== 32'h000F0000) $display("[TB] FAIL abc_vec_W17: got %h want 000F0000", got_data[17]); else passed++;
        checks++; if (got_data[18] !== 32'h7DA86405) $display("[TB] FAIL abc_vec_W18: got %h want 7DA86405", got_data[18]); else passed++;
        checks++; if (got_data[63] !== 32'h12B1EDEB) $display("[TB] FAIL abc_vec_W63: got %h want 12B1EDEB", got_data[63]); else passed++;
        checks++; if (done_pulses !== 1) $display("[TB] FAIL abc_done_pulses: got %0d want 1", done_pulses); else passed++;
        checks++; if (done_cyc !== acc_cyc[63] + 1) $display("[TB] FAIL abc_done_cycle: got %0d want %0d", done_cyc, acc_cyc[63] + 1); else passed++;
        checks++; if (acc_cyc[63] - acc_cyc[16] !== 47) $display("[TB] FAIL abc_throughput: got %0d cycles want 47", acc_cyc[63] - acc_cyc[16]); else passed++;
`ifdef MSG_SCHED_PASSTHRU_EN
        checks++; if (first_valid_cyc !== cap_cyc[0] + 1) $display("[TB] FAIL abc_first_valid: got %0d want %0d", first_valid_cyc, cap_cyc[0] + 1); else passed++;
`else
        checks++; if (first_valid_cyc !== cap_cyc[15] + 1) $display("[TB] FAIL abc_first_valid: got %0d want %0d", first_valid_cyc, cap_cyc[15] + 1); else passed++;
        checks++; if (first_valid_cyc < 17) $display("[TB] FAIL abc_start_latency: got %0d want >=17", first_valid_cyc); else passed++;
        checks++; if (acc_cyc[63] - acc_cyc[0] !== 63) $display("[TB] FAIL abc_emit_rate: got %0d cycles want 63", acc_cyc[63] - acc_cyc[0]); else passed++;
`endif
    endtask

    task automatic test_address_delay();
        fill_random();
        run_block(4'd3, 3, 1'b0, 1'b0, -1);
        checks++; if (timeout) $display("[TB] FAIL addr_timeout: got %0d words want 64", n_got); else passed++;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (addr_log[k] !== 8'(8'h30 + k))
                $display("[TB] FAIL addr_seq_%0d: got %h want %h", k, addr_log[k], 8'(8'h30 + k));
            else passed++;
        end
        checks++; if (n_cap !== 16) $display("[TB] FAIL addr_captures: got %0d want 16", n_cap); else passed++;
        checks++; if (addr_err !== 0) $display("[TB] FAIL addr_stable: got %0d changes want 0", addr_err); else passed++;
        checks++; if (extra_req !== 0) $display("[TB] FAIL addr_req_after_fetch: got %0d want 0", extra_req); else passed++;
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (got_data[k] !== exp_w[k] || got_idx[k] !== k)
                $display("[TB] FAIL addr_W%0d: got %h idx %0d want %h idx %0d", k, got_data[k], got_idx[k], exp_w[k], k);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        fill_abc();
        run_block(4'd0, 0, 1'b1, 1'b0, -1);
        checks++; if (timeout) $display("[TB] FAIL bp_timeout: got %0d words want 64", n_got); else passed++;
        checks++; if (n_got !== 64) $display("[TB] FAIL bp_count: got %0d want 64", n_got); else passed++;
        checks++; if (hold_err !== 0) $display("[TB] FAIL bp_hold_stable: got %0d changes want 0", hold_err); else passed++;
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (got_data[k] !== exp_w[k] || got_idx[k] !== k)
                $display("[TB] FAIL bp_W%0d: got %h idx %0d want %h idx %0d", k, got_data[k], got_idx[k], exp_w[k], k);
            else passed++;
        end
        checks++; if (done_pulses !== 1) $display("[TB] FAIL bp_done_pulses: got %0d want 1", done_pulses); else passed++;
    endtask

    task automatic test_start_ignored();
        logic [3:0] blk;
        blk = 4'($urandom_range(0, 15));
        fill_random();
        run_block(blk, 1, 1'b1, 1'b1, -1);
        checks++; if (timeout) $display("[TB] FAIL poke_timeout: got %0d words want 64", n_got); else passed++;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (addr_log[k] !== {blk, 4'(k)})
                $display("[TB] FAIL poke_addr_%0d: got %h want %h", k, addr_log[k], {blk, 4'(k)});
            else passed++;
        end
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (got_data[k] !== exp_w[k] || got_idx[k] !== k)
                $display("[TB] FAIL poke_W%0d: got %h idx %0d want %h idx %0d", k, got_data[k], got_idx[k], exp_w[k], k);
            else passed++;
        end
        checks++; if (n_got !== 64) $display("[TB] FAIL poke_count: got %0d want 64", n_got); else passed++;
        checks++; if (done_pulses !== 1) $display("[TB] FAIL poke_done_pulses: got %0d want 1", done_pulses); else passed++;
    endtask

    task automatic test_reset_midblock();
        fill_abc();
        run_block(4'd5, 0, 1'b0, 1'b0, 40);
        checks++; if (!aborted) $display("[TB] FAIL rst_reach_t40: got %0d words want abort at 40", n_got); else passed++;
        @(negedge clk);
        checks++; if (w_valid !== 1'b0 || req_word !== 1'b0) $display("[TB] FAIL rst_mid_handshake: got w_valid %b req_word %b want 0 0", w_valid, req_word); else passed++;
        checks++; if (w_data !== 32'h0 || w_index !== 6'h0) $display("[TB] FAIL rst_mid_data: got %h idx %0d want 0 idx 0", w_data, w_index); else passed++;
        checks++; if (busy !== 1'b0 || block_done !== 1'b0) $display("[TB] FAIL rst_mid_state: got busy %b done %b want 0 0", busy, block_done); else passed++;
        checks++; if (word_address !== 8'h0) $display("[TB] FAIL rst_mid_address: got %h want 0", word_address); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || block_done !== 1'b0) $display("[TB] FAIL rst_mid_idle: got busy %b done %b want 0 0", busy, block_done); else passed++;
        run_block(4'd5, 0, 1'b0, 1'b0, -1);
        checks++; if (addr_log[0] !== 8'h50) $display("[TB] FAIL rst_refetch_addr0: got %h want 50", addr_log[0]); else passed++;
        checks++; if (got_data[63] !== exp_w[63] || n_got !== 64) $display("[TB] FAIL rst_refetch_W63: got %h n %0d want %h n 64", got_data[63], n_got, exp_w[63]); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 3; b++) begin
            logic [3:0] blk;
            blk = 4'($urandom_range(0, 15));
            fill_random();
            run_block(blk, int'($urandom_range(0, 2)), 1'b1, 1'b0, -1);
            checks++; if (timeout) $display("[TB] FAIL b2b_timeout_%0d: got %0d words want 64", b, n_got); else passed++;
            checks++; if (addr_log[15] !== {blk, 4'hF}) $display("[TB] FAIL b2b_addr_%0d: got %h want %h", b, addr_log[15], {blk, 4'hF}); else passed++;
            for (int k = 0; k < 64; k++) begin
                checks++;
                if (got_data[k] !== exp_w[k] || got_idx[k] !== k)
                    $display("[TB] FAIL b2b_%0d_W%0d: got %h idx %0d want %h idx %0d", b, k, got_data[k], got_idx[k], exp_w[k], k);
                else passed++;
            end
            checks++; if (done_pulses !== 1) $display("[TB] FAIL b2b_done_%0d: got %0d want 1", b, done_pulses); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_abc_stream();
        test_address_delay();
        test_backpressure();
        test_start_ignored();
        test_reset_midblock();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
